// File: rtl/xctcmsg_receive_matcher.sv
// Receive-side matcher: buffers incoming messages in an oldest-first compacting queue
// and serves RECV/AVAIL requests by masked metadata match, returning results to writeback.
module xctcmsg_receive_matcher #(
    parameter int BUFFER_DEPTH      = 4,
    parameter int COUNT_WIDTH       = $clog2(BUFFER_DEPTH + 1),
    parameter int PASSTHROUGH_WIDTH = 8,
    localparam int META_W = 64,
    localparam int DATA_W = 64,
    localparam int MSG_W  = META_W + DATA_W,
    localparam int REQ_W  = 1 + 2 * META_W + PASSTHROUGH_WIDTH,
    localparam int WB_W   = DATA_W + PASSTHROUGH_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    // req_data_i = {is_avail, meta[63:0], meta_mask[63:0], passthrough}
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [REQ_W-1:0]       req_data_i,
    // msg_data_i = {meta[63:0], data[63:0]}; meta = {tag[31:0], addr[31:0]}
    input  logic                   msg_valid_i,
    output logic                   msg_ready_o,
    input  logic [MSG_W-1:0]       msg_data_i,
    // wb_data_o = {value[63:0], passthrough}
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [WB_W-1:0]        wb_data_o,
    output logic [COUNT_WIDTH-1:0] buffer_count_o
);
    localparam int IDX_W = $clog2(BUFFER_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_RESP} state_t;

    state_t                       state_q;
    logic [COUNT_WIDTH-1:0]       count_q, count_d;
    logic [META_W-1:0]            ent_meta_q [BUFFER_DEPTH];
    logic [META_W-1:0]            ent_meta_d [BUFFER_DEPTH];
    logic [DATA_W-1:0]            ent_data_q [BUFFER_DEPTH];
    logic [DATA_W-1:0]            ent_data_d [BUFFER_DEPTH];
    logic                         req_avail_q;
    logic [META_W-1:0]            req_meta_q, req_mask_q;
    logic [PASSTHROUGH_WIDTH-1:0] req_pt_q;
    logic                         wb_valid_q;
    logic [WB_W-1:0]              wb_data_q;

    logic [BUFFER_DEPTH-1:0]      match_vec;
    logic [COUNT_WIDTH-1:0]       avail_cnt;
    logic [IDX_W-1:0]             sel_idx;
    logic                         sel_found;
    logic                         req_fire, do_accept, do_remove;
    logic [COUNT_WIDTH-1:0]       wr_idx;

    assign req_ready_o    = (state_q == S_IDLE) && !rst;
    assign req_fire       = req_valid_i && req_ready_o;
    assign msg_ready_o    = (count_q < COUNT_WIDTH'(BUFFER_DEPTH));
    assign do_accept      = msg_valid_i && msg_ready_o;
    assign do_remove      = (state_q == S_MATCH) && !req_avail_q && sel_found;
    assign wr_idx         = count_q - COUNT_WIDTH'(do_remove);
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign buffer_count_o = count_q;

    // Parallel compare over registered entries; a message arriving this cycle is not yet visible.
    always_comb begin
        match_vec = '0;
        avail_cnt = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < BUFFER_DEPTH; k++) begin
            if (COUNT_WIDTH'(k) < count_q && ((ent_meta_q[k] ^ req_meta_q) & req_mask_q) == '0)
                match_vec[k] = 1'b1;
            avail_cnt = avail_cnt + COUNT_WIDTH'(match_vec[k]);
        end
        for (int k = BUFFER_DEPTH - 1; k >= 0; k--) begin
            if (match_vec[k]) begin
                sel_idx   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
    end

    // Removal compacts first, then the new message lands just past the surviving entries.
    always_comb begin
        ent_meta_d = ent_meta_q;
        ent_data_d = ent_data_q;
        if (do_remove) begin
            for (int k = 0; k < BUFFER_DEPTH - 1; k++) begin
                if (k >= int'(sel_idx)) begin
                    ent_meta_d[k] = ent_meta_q[k+1];
                    ent_data_d[k] = ent_data_q[k+1];
                end
            end
        end
        if (do_accept) begin
            for (int k = 0; k < BUFFER_DEPTH; k++) begin
                if (wr_idx == COUNT_WIDTH'(k)) begin
                    ent_meta_d[k] = msg_data_i[MSG_W-1:DATA_W];
                    ent_data_d[k] = msg_data_i[DATA_W-1:0];
                end
            end
        end
        count_d = count_q + COUNT_WIDTH'(do_accept) - COUNT_WIDTH'(do_remove);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            count_q <= count_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) state_q <= S_MATCH;
                end
                S_MATCH: begin
                    if (req_avail_q) begin
                        wb_data_q  <= {DATA_W'(avail_cnt), req_pt_q};
                        wb_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (sel_found) begin
                        wb_data_q  <= {ent_data_q[sel_idx], req_pt_q};
                        wb_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Payload storage needs no reset: validity is carried entirely by count_q and the FSM.
    always_ff @(posedge clk) begin
        ent_meta_q <= ent_meta_d;
        ent_data_q <= ent_data_d;
        if (req_fire) {req_avail_q, req_meta_q, req_mask_q, req_pt_q} <= req_data_i;
    end

endmodule
